// File: rtl/lsu_mem_if_if.sv
// Execution-unit op handshake plus data-memory grant/rvalid bus, seen from the LSU (master)
// and from the execution unit / memory side (slave).
interface lsu_mem_if_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              op_valid_i;
    logic              op_ready_o;
    logic              op_we_i;
    logic [ADDR_W-1:0] op_addr_i;
    logic [DATA_W-1:0] op_wdata_i;
    logic              done_o;
    logic              err_o;
    logic [DATA_W-1:0] rdata_o;
    logic              busy_o;
    logic              data_mem_rd_enb_o;
    logic              data_mem_wr_enb_o;
    logic [ADDR_W-1:0] data_mem_addr_o;
    logic [DATA_W-1:0] data_mem_wr_data_o;
    logic              data_mem_gnt_i;
    logic              data_mem_rvalid_i;
    logic [DATA_W-1:0] data_mem_rd_data_i;

    modport master (
        input  op_valid_i, op_we_i, op_addr_i, op_wdata_i,
        input  data_mem_gnt_i, data_mem_rvalid_i, data_mem_rd_data_i,
        output op_ready_o, done_o, err_o, rdata_o, busy_o,
        output data_mem_rd_enb_o, data_mem_wr_enb_o, data_mem_addr_o, data_mem_wr_data_o
    );

    modport slave (
        output op_valid_i, op_we_i, op_addr_i, op_wdata_i,
        output data_mem_gnt_i, data_mem_rvalid_i, data_mem_rd_data_i,
        input  op_ready_o, done_o, err_o, rdata_o, busy_o,
        input  data_mem_rd_enb_o, data_mem_wr_enb_o, data_mem_addr_o, data_mem_wr_data_o
    );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit: one op per valid/ready handshake, variable-latency memory via grant/rvalid.
// done_o at least 2 cycles after accept; op_ready_o low (core stalled) until done, abort on timeout.
module lsu_mem_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input logic         clk,
    input logic         rst,
    lsu_mem_if_if.master bus
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;
    logic              err_q;
    logic [TW-1:0]     timer_q;
    logic [TW-1:0]     timer_d;
    logic              complete;
    logic              expire;

    always_comb begin
        timer_d = (&timer_q) ? timer_q : timer_q + TW'(1);
    end

    // Completion is checked before expiry in the FSM, so a response on the last allowed cycle wins.
    assign expire   = (TIMEOUT != 0) && (timer_d == TW'(TIMEOUT));
    assign complete = ((state_q == REQ) && bus.data_mem_gnt_i && bus.data_mem_rvalid_i) ||
                      ((state_q == WAIT) && bus.data_mem_rvalid_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.op_valid_i) begin
                        we_q    <= bus.op_we_i;
                        addr_q  <= bus.op_addr_i;
                        wdata_q <= bus.op_wdata_i;
                        timer_q <= '0;
                        state_q <= REQ;
                    end
                end
                REQ, WAIT: begin
                    if (complete) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        if (!we_q) begin
                            rdata_q <= bus.data_mem_rd_data_i;
                        end
                    end else if (expire) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_d;
                        if ((state_q == REQ) && bus.data_mem_gnt_i) begin
                            state_q <= WAIT;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign bus.op_ready_o         = (state_q == IDLE);
    assign bus.busy_o             = (state_q != IDLE);
    assign bus.data_mem_rd_enb_o  = (state_q == REQ) && !we_q;
    assign bus.data_mem_wr_enb_o  = (state_q == REQ) && we_q;
    assign bus.data_mem_addr_o    = addr_q;
    assign bus.data_mem_wr_data_o = wdata_q;
    assign bus.done_o             = done_q;
    assign bus.err_o              = err_q;
    assign bus.rdata_o            = rdata_q;
endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: transaction-level model predicts latency, error and load data per op.
module tb_lsu_mem_if;
    localparam int T = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_mem_if_if #(.DATA_W(8),  .ADDR_W(8))  ia ();
    lsu_mem_if_if #(.DATA_W(16), .ADDR_W(12)) ib ();

    lsu_mem_if #(.DATA_W(8),  .ADDR_W(8),  .TIMEOUT(T)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
    lsu_mem_if #(.DATA_W(16), .ADDR_W(12), .TIMEOUT(T)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

    int checks   = 0;
    int failures = 0;
    logic [7:0] model_rdata;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic present(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        ia.op_valid_i = 1'b1;
        ia.op_we_i    = we;
        ia.op_addr_i  = addr;
        ia.op_wdata_i = wdata;
    endtask

    // Called at the negedge of the first cycle after accept; returns at the negedge of the done cycle.
    task automatic run_mem(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           input int g, input int r, input logic [7:0] rdat, input string nm);
        int span, lat, k, enb_cnt, exp_enb;
        bit exp_err, seen, exp_req;
        logic [3:0] ev, gv;
        span    = g + 1 + r;
        exp_err = (span > T);
        lat     = (exp_err ? T : span) + 1;
        exp_enb = (g + 1 < T) ? g + 1 : T;
        k = 1; seen = 0; enb_cnt = 0;
        while (!seen && k <= 60) begin
            if (ia.done_o === 1'b1) begin
                seen = 1;
                if (!we && !exp_err) model_rdata = rdat;
                checks++;
                if (k != lat) begin
                    failures++;
                    $display("FAIL %s latency got=%0d exp=%0d", nm, k, lat);
                end
                checks++;
                if ({ia.err_o, ia.op_ready_o, ia.busy_o} !== {exp_err, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL %s err/ready/busy got=%b exp=%b", nm,
                             {ia.err_o, ia.op_ready_o, ia.busy_o}, {exp_err, 1'b1, 1'b0});
                end
                checks++;
                if (ia.rdata_o !== model_rdata) begin
                    failures++;
                    $display("FAIL %s rdata got=%h exp=%h", nm, ia.rdata_o, model_rdata);
                end
                ia.data_mem_gnt_i    = 1'b0;
                ia.data_mem_rvalid_i = 1'b0;
            end else begin
                exp_req = (k <= g + 1);
                ev = {1'b1, 1'b0, exp_req && !we, exp_req && we};
                gv = {ia.busy_o, ia.op_ready_o, ia.data_mem_rd_enb_o, ia.data_mem_wr_enb_o};
                checks++;
                if (gv !== ev) begin
                    failures++;
                    $display("FAIL %s strobes cyc=%0d got=%b exp=%b", nm, k, gv, ev);
                end
                if (ia.data_mem_rd_enb_o || ia.data_mem_wr_enb_o) enb_cnt++;
                if (exp_req) begin
                    checks++;
                    if (ia.data_mem_addr_o !== addr || (we && ia.data_mem_wr_data_o !== wdata)) begin
                        failures++;
                        $display("FAIL %s bus cyc=%0d addr=%h/%h wdata=%h/%h", nm, k,
                                 ia.data_mem_addr_o, addr, ia.data_mem_wr_data_o, wdata);
                    end
                end
                // Stray rvalid before the grant and stray gnt in WAIT must both be ignored.
                ia.data_mem_gnt_i     = (k == g + 1) || (k > g + 1 && $urandom_range(0, 3) == 0);
                ia.data_mem_rvalid_i  = (k == g + 1 + r) || (k < g + 1 && $urandom_range(0, 3) == 0);
                ia.data_mem_rd_data_i = (k == g + 1 + r) ? rdat : 8'($urandom);
                @(negedge clk);
                k++;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s no done_o within bound", nm);
        end else if (enb_cnt != exp_enb) begin
            failures++;
            $display("FAIL %s strobe cycles got=%0d exp=%0d", nm, enb_cnt, exp_enb);
        end
    endtask

    task automatic do_op(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input int g, input int r, input logic [7:0] rdat, input string nm);
        present(we, addr, wdata);
        @(negedge clk);
        ia.op_valid_i = 1'b0;
        run_mem(we, addr, wdata, g, r, rdat, nm);
        @(negedge clk);
    endtask

    task automatic init_inputs();
        ia.op_valid_i = 0; ia.op_we_i = 0; ia.op_addr_i = '0; ia.op_wdata_i = '0;
        ia.data_mem_gnt_i = 0; ia.data_mem_rvalid_i = 0; ia.data_mem_rd_data_i = '0;
        ib.op_valid_i = 0; ib.op_we_i = 0; ib.op_addr_i = '0; ib.op_wdata_i = '0;
        ib.data_mem_gnt_i = 0; ib.data_mem_rvalid_i = 0; ib.data_mem_rd_data_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({ia.op_ready_o, ia.busy_o, ia.done_o, ia.err_o, ia.data_mem_rd_enb_o, ia.data_mem_wr_enb_o}
            !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=100000", {ia.op_ready_o, ia.busy_o, ia.done_o,
                     ia.err_o, ia.data_mem_rd_enb_o, ia.data_mem_wr_enb_o});
        end
        checks++;
        if ({ia.rdata_o, ia.data_mem_addr_o, ia.data_mem_wr_data_o} !== 24'h0) begin
            failures++;
            $display("FAIL reset_regs got=%h exp=0", {ia.rdata_o, ia.data_mem_addr_o, ia.data_mem_wr_data_o});
        end
        checks++;
        if ({ib.op_ready_o, ib.rdata_o} !== {1'b1, 16'h0}) begin
            failures++;
            $display("FAIL reset_wide got=%h exp=10000", {ib.op_ready_o, ib.rdata_o});
        end
        rst = 1'b0;
        model_rdata = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_zero_wait_load();
        do_op(1'b0, 8'h3C, 8'h00, 0, 0, 8'hA5, "zero_wait_load");
    endtask

    task automatic test_delayed_store();
        do_op(1'b1, 8'h10, 8'h7E, 3, 2, 8'h55, "delayed_store");
    endtask

    task automatic test_timeout();
        do_op(1'b0, 8'h22, 8'h00, 40, 0, 8'h99, "timeout_nognt");
        // Late response after abort, presented while idle.
        ia.data_mem_rvalid_i = 1'b1; ia.data_mem_rd_data_i = 8'hC3;
        @(negedge clk);
        ia.data_mem_rvalid_i = 1'b0;
        checks++;
        if ({ia.done_o, ia.op_ready_o, ia.rdata_o} !== {1'b0, 1'b1, model_rdata}) begin
            failures++;
            $display("FAIL late_rvalid got=%h exp=%h", {ia.done_o, ia.op_ready_o, ia.rdata_o},
                     {1'b0, 1'b1, model_rdata});
        end
        do_op(1'b0, 8'h31, 8'h00, 14, 0, 8'h6B, "timeout_edge_ok");
        do_op(1'b0, 8'h32, 8'h00, 13, 2, 8'h4D, "timeout_edge_err");
        do_op(1'b1, 8'h33, 8'h5A, 2, 20, 8'h00, "timeout_in_wait");
    endtask

    task automatic test_back_to_back();
        present(1'b0, 8'h81, 8'h00);
        @(negedge clk);
        present(1'b1, 8'h82, 8'hE7);
        run_mem(1'b0, 8'h81, 8'h00, 1, 1, 8'h3E, "b2b_first");
        @(negedge clk);
        ia.op_valid_i = 1'b0;
        run_mem(1'b1, 8'h82, 8'hE7, 0, 2, 8'h00, "b2b_second");
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ia.busy_o, ia.data_mem_rd_enb_o, ia.data_mem_wr_enb_o, ia.done_o} !== 4'b0000) begin
                failures++;
                $display("FAIL b2b_extra_op cyc=%0d got=%b exp=0000", i,
                         {ia.busy_o, ia.data_mem_rd_enb_o, ia.data_mem_wr_enb_o, ia.done_o});
            end
            @(negedge clk);
        end
    endtask

    task automatic check_async_reset(input string nm);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ia.data_mem_rd_enb_o, ia.data_mem_wr_enb_o, ia.op_ready_o, ia.done_o, ia.busy_o}
            !== 5'b00100) begin
            failures++;
            $display("FAIL %s got=%b exp=00100", nm, {ia.data_mem_rd_enb_o, ia.data_mem_wr_enb_o,
                     ia.op_ready_o, ia.done_o, ia.busy_o});
        end
        @(negedge clk);
        rst = 1'b0;
        model_rdata = 8'h00;
    endtask

    task automatic test_reset_mid_op();
        present(1'b1, 8'h44, 8'h12);
        @(negedge clk);
        ia.op_valid_i = 1'b0;
        check_async_reset("reset_mid_req");
        present(1'b0, 8'h45, 8'h00);
        @(negedge clk);
        ia.op_valid_i = 1'b0;
        ia.data_mem_gnt_i = 1'b1;
        @(negedge clk);
        ia.data_mem_gnt_i = 1'b0;
        checks++;
        if ({ia.busy_o, ia.data_mem_rd_enb_o} !== 2'b10) begin
            failures++;
            $display("FAIL wait_state got=%b exp=10", {ia.busy_o, ia.data_mem_rd_enb_o});
        end
        check_async_reset("reset_mid_wait");
        @(negedge clk);
        checks++;
        if (ia.done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done got=%b exp=0", ia.done_o);
        end
        do_op(1'b0, 8'h46, 8'h00, 1, 1, 8'hD2, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic we;
            int g, r;
            we = 1'($urandom);
            g  = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 16) : $urandom_range(0, 5);
            r  = $urandom_range(0, 4);
            do_op(we, 8'($urandom), 8'($urandom), g, r, 8'($urandom), "random");
        end
    endtask

    task automatic test_wide();
        logic [11:0] a2;
        logic [15:0] d2;
        ib.op_valid_i = 1'b1; ib.op_we_i = 1'b0; ib.op_addr_i = 12'hFFF;
        @(negedge clk);
        ib.op_valid_i = 1'b0;
        checks++;
        if ({ib.data_mem_rd_enb_o, ib.data_mem_wr_enb_o, ib.data_mem_addr_o} !== {2'b10, 12'hFFF}) begin
            failures++;
            $display("FAIL wide_req got=%h exp=%h", {ib.data_mem_rd_enb_o, ib.data_mem_wr_enb_o,
                     ib.data_mem_addr_o}, {2'b10, 12'hFFF});
        end
        ib.data_mem_gnt_i = 1'b1; ib.data_mem_rvalid_i = 1'b1; ib.data_mem_rd_data_i = 16'hBEEF;
        @(negedge clk);
        ib.data_mem_gnt_i = 1'b0; ib.data_mem_rvalid_i = 1'b0; ib.data_mem_rd_data_i = 16'h0;
        checks++;
        if ({ib.done_o, ib.err_o, ib.rdata_o} !== {2'b10, 16'hBEEF}) begin
            failures++;
            $display("FAIL wide_load got=%h exp=%h", {ib.done_o, ib.err_o, ib.rdata_o}, {2'b10, 16'hBEEF});
        end
        a2 = 12'($urandom) | 12'h800;
        d2 = 16'($urandom);
        ib.op_valid_i = 1'b1; ib.op_addr_i = a2;
        @(negedge clk);
        ib.op_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({ib.data_mem_rd_enb_o, ib.data_mem_addr_o} !== {1'b1, a2}) begin
            failures++;
            $display("FAIL wide_addr got=%h exp=%h", {ib.data_mem_rd_enb_o, ib.data_mem_addr_o}, {1'b1, a2});
        end
        ib.data_mem_gnt_i = 1'b1; ib.data_mem_rvalid_i = 1'b1; ib.data_mem_rd_data_i = d2;
        @(negedge clk);
        ib.data_mem_gnt_i = 1'b0; ib.data_mem_rvalid_i = 1'b0;
        checks++;
        if ({ib.done_o, ib.rdata_o} !== {1'b1, d2}) begin
            failures++;
            $display("FAIL wide_load2 got=%h exp=%h", {ib.done_o, ib.rdata_o}, {1'b1, d2});
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_delayed_store();
        test_timeout();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
